// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token codes, FSM state encoding and the
// data-word decode helper, common to the channel decoder and encoder.
package tmds_pkg;

  localparam logic [9:0] CTRL_TOK_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOK_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOK_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOK_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    ST_SEARCH    = 2'd0,
    ST_SLIP_WAIT = 2'd1,
    ST_LOCKED    = 2'd2
  } tmds_state_e;

  // Undo the optional inversion (bit 9), then the XOR/XNOR chain (bit 8).
  function automatic logic [7:0] tmds_data_decode(input logic [9:0] word);
    logic [7:0] d;
    logic [7:0] p;
    d    = word[9] ? ~word[7:0] : word[7:0];
    p[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      p[i] = word[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return p;
  endfunction

endpackage

// File: rtl/tmds_word_decode.sv
// Combinational classification of one 10-bit TMDS word into a control token
// or a decoded pixel byte.
module tmds_word_decode
  import tmds_pkg::*;
(
  input  logic [9:0] word,
  output logic       is_ctrl,
  output logic [1:0] ctrl,
  output logic [7:0] pixel
);

  always_comb begin
    is_ctrl = 1'b1;
    ctrl    = 2'b00;
    pixel   = tmds_data_decode(word);
    case (word)
      CTRL_TOK_00: ctrl = 2'b00;
      CTRL_TOK_01: ctrl = 2'b01;
      CTRL_TOK_10: ctrl = 2'b10;
      CTRL_TOK_11: ctrl = 2'b11;
      default:     is_ctrl = 1'b0;
    endcase
  end

endmodule

// File: rtl/tmds_channel_decoder.sv
// TMDS channel decoder: word alignment via bitslip search, lock tracking and a
// 2-stage decode pipeline. Define TMDS_DEC_SLIP_STATS_EN for the bitslip counter.
//
// state        | meaning
// -------------+------------------------------------------------------------
// ST_SEARCH    | counting consecutive control tokens; bitslip after dwell limit
// ST_SLIP_WAIT | deserializer settling after a bitslip, input ignored
// ST_LOCKED    | aligned; lost after too long without a control token
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int LOCK_CNT    = 32,
  parameter int SEARCH_CNT  = 2048,
  parameter int SLIP_WAIT   = 4,
  parameter int NO_CTRL_MAX = 4095
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [9:0]  i_tmds,
  output logic        o_bitslip,
  output logic        o_locked,
  output logic        o_de,
  output logic [1:0]  o_ctrl,
  output logic [7:0]  o_pixel,
  output logic [15:0] o_slip_cnt
);

  localparam int RUN_W   = $clog2(LOCK_CNT + 1);
  localparam int DWELL_W = $clog2(SEARCH_CNT + 1);
  localparam int WAIT_W  = $clog2(SLIP_WAIT + 1);
  localparam int IDLE_W  = $clog2(NO_CTRL_MAX + 1);

  tmds_state_e        state, state_nxt;
  logic [RUN_W-1:0]   run_cnt, run_nxt;
  logic [DWELL_W-1:0] dwell_cnt, dwell_nxt;
  logic [WAIT_W-1:0]  wait_cnt, wait_nxt;
  logic [IDLE_W-1:0]  idle_cnt, idle_nxt;
  logic               slip_nxt;
  logic               bitslip_r, locked_r;

  logic       is_ctrl;
  logic [1:0] ctrl;
  logic [7:0] pixel;

  logic       s1_is_ctrl;
  logic [1:0] s1_ctrl;
  logic [7:0] s1_pixel;
  logic       out_de;
  logic [1:0] out_ctrl;
  logic [7:0] out_pixel;

  tmds_word_decode u_word_decode (
    .word    (i_tmds),
    .is_ctrl (is_ctrl),
    .ctrl    (ctrl),
    .pixel   (pixel)
  );

  always_comb begin
    state_nxt = state;
    run_nxt   = run_cnt;
    dwell_nxt = dwell_cnt;
    wait_nxt  = wait_cnt;
    idle_nxt  = idle_cnt;
    slip_nxt  = 1'b0;
    case (state)
      ST_SEARCH: begin
        // Lock completion wins over a simultaneous dwell expiry.
        if (is_ctrl && run_cnt == RUN_W'(LOCK_CNT - 1)) begin
          state_nxt = ST_LOCKED;
          run_nxt   = '0;
          dwell_nxt = '0;
          idle_nxt  = '0;
        end else if (dwell_cnt == DWELL_W'(SEARCH_CNT - 1)) begin
          state_nxt = ST_SLIP_WAIT;
          slip_nxt  = 1'b1;
          run_nxt   = '0;
          dwell_nxt = '0;
          wait_nxt  = '0;
        end else begin
          dwell_nxt = dwell_cnt + DWELL_W'(1);
          run_nxt   = is_ctrl ? run_cnt + RUN_W'(1) : '0;
        end
      end
      ST_SLIP_WAIT: begin
        if (wait_cnt == WAIT_W'(SLIP_WAIT - 1)) begin
          state_nxt = ST_SEARCH;
          wait_nxt  = '0;
          run_nxt   = '0;
          dwell_nxt = '0;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      ST_LOCKED: begin
        if (is_ctrl) begin
          idle_nxt = '0;
        end else if (idle_cnt == IDLE_W'(NO_CTRL_MAX - 1)) begin
          state_nxt = ST_SEARCH;
          idle_nxt  = '0;
          run_nxt   = '0;
          dwell_nxt = '0;
        end else begin
          idle_nxt = idle_cnt + IDLE_W'(1);
        end
      end
      default: state_nxt = ST_SEARCH;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_SEARCH;
      run_cnt    <= '0;
      dwell_cnt  <= '0;
      wait_cnt   <= '0;
      idle_cnt   <= '0;
      bitslip_r  <= 1'b0;
      locked_r   <= 1'b0;
      s1_is_ctrl <= 1'b0;
      s1_ctrl    <= 2'b00;
      s1_pixel   <= 8'h00;
      out_de     <= 1'b0;
      out_ctrl   <= 2'b00;
      out_pixel  <= 8'h00;
    end else begin
      state      <= state_nxt;
      run_cnt    <= run_nxt;
      dwell_cnt  <= dwell_nxt;
      wait_cnt   <= wait_nxt;
      idle_cnt   <= idle_nxt;
      bitslip_r  <= slip_nxt;
      locked_r   <= (state_nxt == ST_LOCKED);
      s1_is_ctrl <= is_ctrl;
      s1_ctrl    <= ctrl;
      s1_pixel   <= is_ctrl ? 8'h00 : pixel;
      out_de     <= ~s1_is_ctrl;
      out_pixel  <= s1_is_ctrl ? 8'h00 : s1_pixel;
      // Control value is held across data periods.
      if (s1_is_ctrl) out_ctrl <= s1_ctrl;
    end
  end

  assign o_bitslip = bitslip_r;
  assign o_locked  = locked_r;
  assign o_de      = out_de & locked_r;
  assign o_ctrl    = locked_r ? out_ctrl  : 2'b00;
  assign o_pixel   = locked_r ? out_pixel : 8'h00;

`ifdef TMDS_DEC_SLIP_STATS_EN
  logic [15:0] slip_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      slip_cnt <= 16'h0000;
    end else if (slip_nxt && slip_cnt != 16'hFFFF) begin
      slip_cnt <= slip_cnt + 16'd1;
    end
  end

  assign o_slip_cnt = slip_cnt;
`else
  assign o_slip_cnt = 16'h0000;
`endif

endmodule

// File: doc/tmds_channel_decoder.md
TMDS_CHANNEL_DECODER -- requirements
Module: tmds_channel_decoder

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 32: consecutive control tokens needed to declare lock.
REQ-002 SHALL have parameter SEARCH_CNT, default 2048: cycles in SEARCH without lock before a bitslip.
REQ-003 SHALL have parameter SLIP_WAIT, default 4: settle cycles after a bitslip pulse.
REQ-004 SHALL have parameter NO_CTRL_MAX, default 4095: cycles in LOCKED without a control token before lock loss.
REQ-005 SHALL have i_clk, input, 1: pixel clock; single clock domain.
REQ-006 SHALL have i_rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have i_tmds, input, 10: deserialized TMDS word, bit 0 first on the wire.
REQ-008 SHALL have o_bitslip, output, 1: one-cycle pulse requesting a 1-bit word-boundary shift from the deserializer.
REQ-009 SHALL have o_locked, output, 1: word alignment achieved.
REQ-010 SHALL have o_de, output, 1: data enable (decoded data period).
REQ-011 SHALL have o_ctrl, output, 2: decoded control bits {c1,c0}.
REQ-012 SHALL have o_pixel, output, 8: decoded pixel byte.
REQ-013 SHALL have o_slip_cnt, output, 16: saturating bitslip count (see Configuration).

Function
REQ-014 SHALL classify control tokens: 10'b1101010100->00, 10'b0010101011->01, 10'b0101010100->10, 10'b1010101011->11; every other word is data.
REQ-015 SHALL decode data as follows: d = i_tmds[9] ? ~i_tmds[7:0] : i_tmds[7:0]; p[0] = d[0]; for i = 1..7, p[i] = d[i]^d[i-1] if i_tmds[8] = 1, else ~(d[i]^d[i-1]).
REQ-016 SHALL register outputs with a fixed 2-cycle latency from i_tmds to o_de/o_ctrl/o_pixel.
REQ-017 SHALL, on a control token while locked, drive o_de = 0, o_ctrl = token value, o_pixel = 0; on data, drive o_de = 1, o_pixel = decoded value, o_ctrl = last control value held.
REQ-018 SHALL force o_de = 0, o_ctrl = 0 and o_pixel = 0 whenever o_locked = 0.
REQ-019 SHALL implement FSM states SEARCH, SLIP_WAIT, LOCKED.
REQ-020 SEARCH SHALL count consecutive control tokens, with any data word clearing the run; a run reaching LOCK_CNT SHALL go to LOCKED.
REQ-021 SEARCH SHALL count its dwell cycles; at SEARCH_CNT without lock it SHALL pulse o_bitslip for exactly one cycle and enter SLIP_WAIT.
REQ-022 SLIP_WAIT SHALL ignore input for SLIP_WAIT cycles, then return to SEARCH with the run and dwell counters cleared.
REQ-023 LOCKED SHALL count cycles since the last control token; reaching NO_CTRL_MAX SHALL return to SEARCH, drop o_locked on the same edge and pulse no bitslip.
REQ-024 SHALL assert o_locked exactly while in LOCKED (registered, changing on the state-transition edge).
REQ-025 SHALL give lock priority when the lock-run completion and SEARCH_CNT expiry occur in the same cycle: go to LOCKED with no bitslip.
REQ-026 SHALL size all counters to their parameters and never wrap.

Reset
REQ-027 While i_rst = 1, the block SHALL enter SEARCH, clear all counters and pipeline stages, and drive o_bitslip = 0, o_locked = 0, o_de = 0, o_ctrl = 0, o_pixel = 0, o_slip_cnt = 0.
REQ-028 Reset asserted mid-lock or mid-SLIP_WAIT SHALL take effect at the next edge, and no bitslip pulse SHALL be issued during reset.

Configuration
REQ-029 With macro TMDS_DEC_SLIP_STATS_EN defined, o_slip_cnt SHALL increment on each o_bitslip pulse and saturate at 16'hFFFF.
REQ-030 Without TMDS_DEC_SLIP_STATS_EN, o_slip_cnt SHALL be tied to 0 and no counter logic SHALL be synthesized.

Structure
REQ-031 The shared package tmds_pkg SHALL hold the four control-token constants and the FSM state encoding, shared with tmds_encoder.
REQ-032 The combinational classify/decode logic SHALL be a sub-module tmds_word_decode (10-bit word in -> is_ctrl, ctrl[1:0], pixel[7:0] out); the FSM, counters and pipeline stay in the top module.

Verification
REQ-033 Drive 40 x 10'b1101010100 after reset -> o_locked = 1 on cycle 32, o_bitslip never pulses.
REQ-034 Once locked, drive data 10'b0100000000 -> two cycles later o_de = 1, o_pixel = 8'h00; drive 10'b1010101011 -> o_de = 0, o_ctrl = 2'b11.
REQ-035 Drive a word stream rotated by 3 bits relative to a model that applies bitslips -> exactly 3 o_bitslip pulses spaced SEARCH_CNT+SLIP_WAIT apart, then lock; with the macro defined, o_slip_cnt = 3.
REQ-036 Once locked, drive 4095 consecutive data words -> o_locked falls, o_de = 0, and SEARCH restarts with no bitslip pulse.
REQ-037 Assert i_rst for 1 cycle while locked -> all outputs 0 on the next cycle; relock requires 32 fresh tokens.
REQ-038 Drive 31 tokens, 1 data word, then 31 tokens -> no lock; the 32nd token of the following run locks.
